// File: rtl/execution_md_pkg.sv
// Shared definitions for the EX stage: EX control field positions, op codes,
// mul/div FSM state type and a helper for HI/LO-dependent ops.
package execution_md_pkg;

    localparam int EX_OP_MSB = 6;
    localparam int EX_OP_LSB = 2;
    localparam int EX_BSEL   = 1;
    localparam int EX_UNS    = 0;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_SLA  = 5'd9;
    localparam logic [4:0] OP_SLT  = 5'd10;
    localparam logic [4:0] OP_LUI  = 5'd11;
    localparam logic [4:0] OP_MULT = 5'd12;
    localparam logic [4:0] OP_DIV  = 5'd13;
    localparam logic [4:0] OP_MFHI = 5'd14;
    localparam logic [4:0] OP_MFLO = 5'd15;
    localparam logic [4:0] OP_MTHI = 5'd16;
    localparam logic [4:0] OP_MTLO = 5'd17;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_t;

    // Ops that read or write HI/LO or start the mul/div unit.
    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage

// File: rtl/execution_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Works on operand magnitudes; the FIX cycle applies signs and writes HI/LO.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  MD_IDLE | waiting for start; MTHI/MTLO may write HI/LO
//  MD_MUL  | shift-add step, NB_REG cycles
//  MD_DIV  | restoring-divide step, NB_REG cycles
//  MD_FIX  | sign correction, divide-by-zero substitution, HI/LO write
module execution_muldiv
    import execution_md_pkg::*;
#(
    parameter int NB_REG = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              op,
    input  logic              uns,
    input  logic [NB_REG-1:0] a,
    input  logic [NB_REG-1:0] b,
    input  logic              mt_hi,
    input  logic              mt_lo,
    output logic              busy,
    output logic [NB_REG-1:0] hi,
    output logic [NB_REG-1:0] lo
);

    localparam int N      = NB_REG;
    localparam int NB_CNT = $clog2(NB_REG);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_REG - 1);

    md_state_t         state, state_next;
    logic [NB_CNT-1:0] cnt;
    logic [2*N-1:0]    acc;
    logic [N-1:0]      opb;
    logic [N-1:0]      a_keep;
    logic              neg_q, neg_r, b_zero, is_div;

    logic [N-1:0]      a_mag, b_mag;
    logic [N:0]        mul_sum, div_diff;
    logic [2*N-1:0]    mul_step, div_step, prod;
    logic [N-1:0]      quo, rem, fix_hi, fix_lo;

    assign busy  = (state != MD_IDLE);
    assign a_mag = (!uns && a[N-1]) ? -a : a;
    assign b_mag = (!uns && b[N-1]) ? -b : b;

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, opb};
    assign mul_step = acc[0] ? {mul_sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};

    // acc = {partial remainder, dividend bits / quotient bits}
    assign div_diff = acc[2*N-1:N-1] - {1'b0, opb};
    assign div_step = div_diff[N] ? {acc[2*N-2:0], 1'b0}
                                  : {div_diff[N-1:0], acc[N-2:0], 1'b1};

    // State register, frozen when the pipeline is disabled.
    always_ff @(posedge clock) begin
        if (reset)
            state <= MD_IDLE;
        else if (en)
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = op ? MD_DIV : MD_MUL;
            MD_MUL,
            MD_DIV:  if (cnt == CNT_LAST) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Operand capture and one iteration step per enabled cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            a_keep <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            is_div <= 1'b0;
        end else if (en) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc    <= {{N{1'b0}}, a_mag};
                        opb    <= b_mag;
                        a_keep <= a;
                        b_zero <= (b == '0);
                        is_div <= op;
                        neg_q  <= !uns && (a[N-1] ^ b[N-1]);
                        neg_r  <= !uns && a[N-1];
                    end
                end
                MD_MUL: begin
                    acc <= mul_step;
                    cnt <= cnt + NB_CNT'(1);
                end
                MD_DIV: begin
                    acc <= div_step;
                    cnt <= cnt + NB_CNT'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Signed result reconstruction for the FIX cycle.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[N-1:0] : acc[N-1:0];
        rem    = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
        if (!is_div) begin
            {fix_hi, fix_lo} = prod;
        end else if (b_zero) begin
            fix_hi = a_keep;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // HI/LO: result write on FIX, otherwise direct moves from operand A.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (en) begin
            if (state == MD_FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else begin
                if (mt_hi) hi <= a;
                if (mt_lo) lo <= a;
            end
        end
    end

endmodule

// File: rtl/execution_md.sv
// MIPS EX stage: operand select, ALU, mul/div unit hookup, HI/LO hazard
// stall and the EX/MEM pipeline registers.
module execution_md
    import execution_md_pkg::*;
#(
    parameter int NB_REG = 32,
    parameter int NB_INM = 16,
    parameter int NB_EX  = 7,
    parameter int NB_MEM = 5,
    parameter int NB_WB  = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_REG-1:0] i_a,
    input  logic [NB_REG-1:0] i_b,
    input  logic [NB_INM-1:0] i_inm,
    input  logic [NB_EX-1:0]  i_ex,
    input  logic [NB_MEM-1:0] i_mem,
    input  logic [NB_WB-1:0]  i_wb,
    input  logic [NB_REG-1:0] i_pc,
    output logic [NB_REG-1:0] o_alu,
    output logic [NB_REG-1:0] o_b,
    output logic [NB_MEM-1:0] o_mem,
    output logic [NB_WB-1:0]  o_wb,
    output logic [NB_REG-1:0] o_pc,
    output logic              o_stall,
    output logic              o_busy
);

    localparam int NB_SH = $clog2(NB_REG);

    logic [4:0]        op;
    logic              b_sel, uns, lt, accept, busy;
    logic [NB_REG-1:0] ext, opnd2, alu_res, hi, lo;
    logic [NB_SH-1:0]  shamt;

    assign op     = i_ex[EX_OP_MSB:EX_OP_LSB];
    assign b_sel  = i_ex[EX_BSEL];
    assign uns    = i_ex[EX_UNS];
    assign ext    = uns ? {{(NB_REG-NB_INM){1'b0}}, i_inm}
                        : {{(NB_REG-NB_INM){i_inm[NB_INM-1]}}, i_inm};
    assign opnd2  = b_sel ? ext : i_b;
    assign shamt  = i_a[NB_SH-1:0];
    assign lt     = uns ? (i_a < opnd2) : ($signed(i_a) < $signed(opnd2));

    assign o_busy  = busy;
    assign o_stall = busy & is_hilo_op(op);
    assign accept  = i_valid & ~o_stall;

    execution_muldiv #(
        .NB_REG (NB_REG)
    ) u_muldiv (
        .clock (i_clock),
        .reset (i_reset),
        .en    (i_valid),
        .start (accept && ((op == OP_MULT) || (op == OP_DIV))),
        .op    (op == OP_DIV),
        .uns   (uns),
        .a     (i_a),
        .b     (i_b),
        .mt_hi (accept && (op == OP_MTHI)),
        .mt_lo (accept && (op == OP_MTLO)),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // ALU result; MFHI/MFLO see HI/LO before any write at this edge.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:          alu_res = i_a + opnd2;
            OP_SUB:          alu_res = i_a - opnd2;
            OP_AND:          alu_res = i_a & opnd2;
            OP_OR:           alu_res = i_a | opnd2;
            OP_XOR:          alu_res = i_a ^ opnd2;
            OP_NOR:          alu_res = ~(i_a | opnd2);
            OP_SRL:          alu_res = opnd2 >> shamt;
            OP_SLL, OP_SLA:  alu_res = opnd2 << shamt;
            OP_SRA:          alu_res = $signed(opnd2) >>> shamt;
            OP_SLT:          alu_res = {{(NB_REG-1){1'b0}}, lt};
            OP_LUI:          alu_res = ext << (NB_REG - NB_INM);
            OP_MFHI:         alu_res = hi;
            OP_MFLO:         alu_res = lo;
            OP_MULT, OP_DIV,
            OP_MTHI, OP_MTLO: alu_res = '0;
            default:         alu_res = '0;
        endcase
    end

    // EX/MEM registers; a stalled cycle issues a bubble but still tracks PC/B.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_alu <= '0;
            o_b   <= '0;
            o_mem <= '0;
            o_wb  <= '0;
            o_pc  <= '0;
        end else if (i_valid) begin
            o_pc <= i_pc;
            o_b  <= i_b;
            if (o_stall) begin
                o_alu <= '0;
                o_mem <= '0;
                o_wb  <= '0;
            end else begin
                o_alu <= alu_res;
                o_mem <= i_mem;
                o_wb  <= i_wb;
            end
        end
    end

endmodule

// File: tb/tb_execution_md.sv
// Self-checking bench for execution_md: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_execution_md;

    logic        tb_clock_i = 1'b0;
    logic        rst, valid;
    logic [31:0] a, b, pc;
    logic [15:0] inm;
    logic [6:0]  ex;
    logic [4:0]  mem;
    logic [7:0]  wb;
    logic [31:0] o_alu, o_b, o_pc;
    logic [4:0]  o_mem;
    logic [7:0]  o_wb;
    logic        o_stall, o_busy;

    int checks = 0;
    int errors = 0;

    execution_md #(
        .NB_REG(32), .NB_INM(16), .NB_EX(7), .NB_MEM(5), .NB_WB(8)
    ) dut (
        .i_clock(tb_clock_i), .i_reset(rst), .i_valid(valid),
        .i_a(a), .i_b(b), .i_inm(inm), .i_ex(ex), .i_mem(mem), .i_wb(wb), .i_pc(pc),
        .o_alu(o_alu), .o_b(o_b), .o_mem(o_mem), .o_wb(o_wb), .o_pc(o_pc),
        .o_stall(o_stall), .o_busy(o_busy)
    );

    always #5 tb_clock_i = ~tb_clock_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_on = 1'b0;
    logic [31:0] m_alu, m_b, m_pc, m_hi, m_lo, p_hi, p_lo;
    logic [4:0]  m_mem;
    logic [7:0]  m_wb;
    int          m_left;

    function automatic logic hilo(input logic [4:0] op);
        return (op >= 5'd12) && (op <= 5'd17);
    endfunction

    function automatic logic [31:0] ext_imm(input logic [15:0] im, input logic us);
        logic [31:0] r;
        r = us ? {16'h0, im} : {{16{im[15]}}, im};
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic us,
                                            input logic [15:0] im, input logic [31:0] h,
                                            input logic [31:0] l);
        logic [63:0] t;
        longint      sx, sy;
        int          sh;
        sh = int'(x[4:0]);
        case (op)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x & y;
            5'd3:  return x | y;
            5'd4:  return x ^ y;
            5'd5:  return ~(x | y);
            5'd6:  return y >> sh;
            5'd7, 5'd9: return y << sh;
            5'd8: begin
                t = {{32{y[31]}}, y} >> sh;
                return t[31:0];
            end
            5'd10: begin
                sx = us ? longint'({32'h0, x}) : longint'($signed(x));
                sy = us ? longint'({32'h0, y}) : longint'($signed(y));
                return (sx < sy) ? 32'd1 : 32'd0;
            end
            5'd11: return {im, 16'h0};
            5'd14: return h;
            5'd15: return l;
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_mult(input logic [31:0] x, input logic [31:0] y, input logic us);
        logic [63:0] p;
        if (us) p = {32'h0, x} * {32'h0, y};
        else    p = 64'(longint'($signed(x)) * longint'($signed(y)));
        p_hi = p[63:32];
        p_lo = p[31:0];
    endtask

    task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic us);
        int sx, sy;
        if (y == 32'h0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = x;
        end else if (!us && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000;
            p_hi = 32'h0;
        end else if (us) begin
            p_lo = x / y;
            p_hi = x % y;
        end else begin
            sx = x;
            sy = y;
            p_lo = sx / sy;
            p_hi = sx % sy;
        end
    endtask

    always @(posedge tb_clock_i) begin
        logic [4:0]  op;
        logic        us, stl;
        logic [31:0] o2, h0, l0;
        if (rst) begin
            m_on = 1'b1;
            m_alu = 0; m_b = 0; m_pc = 0; m_mem = 0; m_wb = 0;
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (valid) begin
            op  = ex[6:2];
            us  = ex[0];
            o2  = ex[1] ? ext_imm(inm, us) : b;
            stl = (m_left != 0) && hilo(op);
            h0  = m_hi;
            l0  = m_lo;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
            m_pc = pc;
            m_b  = b;
            if (stl) begin
                m_alu = 0; m_mem = 0; m_wb = 0;
            end else begin
                m_alu = ref_alu(op, a, o2, us, inm, h0, l0);
                m_mem = mem;
                m_wb  = wb;
                case (op)
                    5'd12: begin ref_mult(a, b, us); m_left = 33; end
                    5'd13: begin ref_div(a, b, us);  m_left = 33; end
                    5'd16: m_hi = a;
                    5'd17: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge tb_clock_i) begin
        if (m_on) begin
            chk("alu",   o_alu, m_alu);
            chk("b",     o_b,   m_b);
            chk("pc",    o_pc,  m_pc);
            chk("mem",   32'(o_mem), 32'(m_mem));
            chk("wb",    32'(o_wb),  32'(m_wb));
            chk("busy",  32'(o_busy), 32'(m_left != 0));
            chk("stall", 32'(o_stall), 32'((m_left != 0) && hilo(ex[6:2])));
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic bs, input logic us, input logic [15:0] im);
        valid = 1'b1;
        ex    = {op, bs, us};
        a     = av;
        b     = bv;
        inm   = im;
        mem   = 5'($urandom);
        wb    = 8'($urandom);
        pc    = $urandom;
    endtask

    task automatic step();
        @(posedge tb_clock_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic bs, input logic us);
        put(op, av, bv, bs, us, 16'($urandom));
        step();
    endtask

    task automatic nop();
        issue(5'd18, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    task automatic issue_wait(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                              input logic us, output int stalls);
        put(op, av, bv, 1'b0, us, 16'h0);
        stalls = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge tb_clock_i);
            if (!o_stall) break;
            stalls++;
            step();
        end
        step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15)) - 32'd8;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int          stalls, busy_n, r;
        logic [4:0]  op;
        rst = 1'b1; valid = 1'b0; a = 0; b = 0; inm = 0; ex = 0; mem = 0; wb = 0; pc = 0;
        step();
        step();
        chk("reset_alu",  o_alu, 32'h0);
        chk("reset_pc",   o_pc,  32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        rst = 1'b0;

        // ADD with control passthrough
        put(5'd0, 32'd1, 32'd1, 1'b0, 1'b0, 16'h0);
        mem = 5'h15; wb = 8'hA5; pc = 32'h0000_0100;
        step();
        chk("add_alu", o_alu, 32'd2);
        chk("add_mem", 32'(o_mem), 32'h15);
        chk("add_wb",  32'(o_wb),  32'hA5);
        chk("add_pc",  o_pc, 32'h100);

        put(5'd11, 32'h0, 32'h0, 1'b1, 1'b1, 16'h0002);
        step();
        chk("lui", o_alu, 32'h0002_0000);
        issue(5'd10, 32'd3, 32'd2, 1'b0, 1'b0);
        chk("slt_3_2", o_alu, 32'd0);
        issue(5'd10, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        chk("sltu_m1_2", o_alu, 32'd0);
        issue(5'd10, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("slt_m1_2", o_alu, 32'd1);

        // MULT -3*7 then idle
        issue(5'd12, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_alu", o_alu, 32'h0);
        repeat (33) nop();
        issue(5'd15, 0, 0, 1'b0, 1'b0);
        chk("mult_lo", o_alu, 32'hFFFF_FFEB);
        issue(5'd14, 0, 0, 1'b0, 1'b0);
        chk("mult_hi", o_alu, 32'hFFFF_FFFF);

        // DIVU by zero with dependent MFHI held
        issue(5'd13, 32'd7, 32'd0, 1'b0, 1'b1);
        issue_wait(5'd14, 0, 0, 1'b0, stalls);
        chk("divz_stalls", 32'(stalls), 32'd33);
        chk("divz_hi", o_alu, 32'd7);
        issue(5'd15, 0, 0, 1'b0, 1'b0);
        chk("divz_lo", o_alu, 32'hFFFF_FFFF);

        // DIV -7/2 with independent ops overlapping
        issue(5'd13, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        issue(5'd0, 32'd5, 32'd6, 1'b0, 1'b0);
        chk("ovl_add", o_alu, 32'd11);
        chk("ovl_busy", 32'(o_busy), 32'd1);
        issue(5'd2, 32'hF0, 32'h3C, 1'b0, 1'b0);
        chk("ovl_and", o_alu, 32'h30);
        issue_wait(5'd15, 0, 0, 1'b0, stalls);
        chk("div_lo", o_alu, 32'hFFFF_FFFD);
        issue(5'd14, 0, 0, 1'b0, 1'b0);
        chk("div_hi", o_alu, 32'hFFFF_FFFF);
        issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue_wait(5'd15, 0, 0, 1'b0, stalls);
        chk("min_lo", o_alu, 32'h8000_0000);
        issue(5'd14, 0, 0, 1'b0, 1'b0);
        chk("min_hi", o_alu, 32'h0);

        // MULT with 5 frozen cycles
        issue(5'd13, 32'd9, 32'd0, 1'b0, 1'b1);
        repeat (33) nop();
        issue(5'd12, 32'd1000, 32'hFFFF_FFFB, 1'b0, 1'b0);
        busy_n = 0;
        while (o_busy && busy_n < 100) begin
            busy_n++;
            put(5'd18, $urandom, $urandom, 1'b0, 1'b0, 16'h0);
            valid = !(busy_n >= 10 && busy_n < 15);
            step();
        end
        chk("freeze_busy", 32'(busy_n), 32'd38);
        issue(5'd15, 0, 0, 1'b0, 1'b0);
        chk("freeze_lo", o_alu, 32'hFFFF_EC78);
        issue(5'd14, 0, 0, 1'b0, 1'b0);
        chk("freeze_hi", o_alu, 32'hFFFF_FFFF);

        // reset mid-DIV
        issue(5'd13, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (3) nop();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(o_busy), 32'h0);
        issue(5'd14, 0, 0, 1'b0, 1'b0);
        chk("rst_hi", o_alu, 32'h0);
        issue(5'd15, 0, 0, 1'b0, 1'b0);
        chk("rst_lo", o_alu, 32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 19);
            op = (r < 18) ? 5'(r) : 5'($urandom_range(18, 31));
            put(op, pick(), pick(), 1'($urandom), 1'($urandom), 16'($urandom));
            valid = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 599) == 0);
            step();
        end
        rst   = 1'b0;
        valid = 1'b1;
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
